// File: rtl/line_window_buffer_pkg.sv
// Shared constants and helpers for the streaming line window buffer.
package line_buf_pkg;

   localparam int BORDER_REPLICATE = 0;
   localparam int BORDER_ZERO      = 1;

   // A zero or oversized runtime width falls back to the full line.
   function automatic int unsigned clamp_width(input int unsigned w, input int unsigned max_w);
      return (w == 0 || w > max_w) ? max_w : w;
   endfunction

endpackage

// File: rtl/line_window_buffer_if.sv
// Pixel-in / window-out handshake bundle for line_window_buffer.
interface line_window_buffer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_ROWS   = 4
);
   logic                                 s_valid;
   logic                                 s_ready;
   logic [DATA_WIDTH-1:0]                s_data;
   logic                                 s_sof;
   logic                                 s_eol;
   logic                                 m_valid;
   logic                                 m_ready;
   logic [NUM_ROWS-1:0][DATA_WIDTH-1:0]  m_rows;
   logic                                 m_sof;
   logic                                 m_eol;
   logic                                 m_full;

   modport slave (
      input  s_valid, s_data, s_sof, s_eol, m_ready,
      output s_ready, m_valid, m_rows, m_sof, m_eol, m_full
   );

   modport master (
      output s_valid, s_data, s_sof, s_eol, m_ready,
      input  s_ready, m_valid, m_rows, m_sof, m_eol, m_full
   );
endinterface

// File: rtl/line_window_buffer_ram.sv
// Single-port line store: combinational read, synchronous write, so a
// same-cycle read at the write address returns the old word.
module line_ram #(
   parameter int DEPTH = 1024,
   parameter int WIDTH = 24,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem [DEPTH];

   assign rdata = mem[addr];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end
endmodule

// File: rtl/line_window_buffer.sv
// Multi-row line buffer: one pixel in, a vertical column of NUM_ROWS pixels out,
// with top-of-frame border masking and a registered, backpressured output.
module line_window_buffer
   import line_buf_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int MAX_WIDTH   = 1024,
   parameter int NUM_ROWS    = 4,
   parameter int BORDER_MODE = BORDER_REPLICATE
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [$clog2(MAX_WIDTH+1)-1:0] cfg_width,
   line_window_buffer_if.slave            bus,
   output logic                           err_eol
);
   localparam int CW = $clog2(MAX_WIDTH+1);
   localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
   localparam int FW = (NUM_ROWS > 2) ? $clog2(NUM_ROWS) : 1;
   localparam int RN = NUM_ROWS - 1;

   logic [AW-1:0] col, eff_col;
   logic [FW-1:0] row_fill, eff_fill;
   logic [CW-1:0] w_lat, eff_w, cfg_clamped;
   logic          accept, last;

   logic [RN-1:0][DATA_WIDTH-1:0]       ram_rd, ram_wr;
   logic [NUM_ROWS-1:0][DATA_WIDTH-1:0] taps, window;

   logic                                m_valid_q, m_sof_q, m_eol_q, m_full_q;
   logic [NUM_ROWS-1:0][DATA_WIDTH-1:0] m_rows_q;

   assign bus.s_ready = !m_valid_q || bus.m_ready;
   assign accept      = bus.s_valid && bus.s_ready;

   // A start-of-frame pixel restarts the frame before it is stored.
   assign cfg_clamped = CW'(clamp_width(32'(cfg_width), MAX_WIDTH));
   assign eff_col     = bus.s_sof ? '0 : col;
   assign eff_fill    = bus.s_sof ? '0 : row_fill;
   assign eff_w       = bus.s_sof ? cfg_clamped : w_lat;
   assign last        = (32'(eff_col) == 32'(eff_w) - 32'd1);

   line_ram #(.DEPTH(MAX_WIDTH), .WIDTH(RN*DATA_WIDTH), .AW(AW)) u_ram (
      .clk   (clk),
      .we    (accept),
      .addr  (eff_col),
      .wdata (ram_wr),
      .rdata (ram_rd)
   );

   for (genvar j = 0; j < RN; j++) begin : g_wr
      if (j == 0) begin : g_new
         assign ram_wr[j] = bus.s_data;
      end else begin : g_shift
         assign ram_wr[j] = ram_rd[j-1];
      end
   end

   // Taps deeper than row_fill are not from this frame yet: mask them.
   for (genvar k = 0; k < NUM_ROWS; k++) begin : g_tap
      if (k == 0) begin : g_cur
         assign taps[k]   = bus.s_data;
         assign window[k] = bus.s_data;
      end else begin : g_old
         assign taps[k]   = ram_rd[k-1];
         assign window[k] = (k <= int'(eff_fill))          ? taps[k] :
                            (BORDER_MODE == BORDER_ZERO)   ? '0      : taps[eff_fill];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col       <= '0;
         row_fill  <= '0;
         w_lat     <= cfg_clamped;
         err_eol   <= 1'b0;
         m_valid_q <= 1'b0;
         m_rows_q  <= '0;
         m_sof_q   <= 1'b0;
         m_eol_q   <= 1'b0;
         m_full_q  <= 1'b0;
      end else if (accept) begin
         w_lat <= eff_w;
         if (bus.s_eol || last) begin
            col      <= '0;
            row_fill <= (eff_fill == FW'(RN)) ? eff_fill : eff_fill + FW'(1);
         end else begin
            col      <= eff_col + AW'(1);
            row_fill <= eff_fill;
         end
         if (bus.s_eol != last) err_eol <= 1'b1;
         m_valid_q <= 1'b1;
         m_rows_q  <= window;
         m_sof_q   <= bus.s_sof;
         m_eol_q   <= bus.s_eol;
         m_full_q  <= (eff_fill == FW'(RN));
      end else if (bus.m_ready) begin
         m_valid_q <= 1'b0;
      end
   end

   assign bus.m_valid = m_valid_q;
   assign bus.m_rows  = m_rows_q;
   assign bus.m_sof   = m_sof_q;
   assign bus.m_eol   = m_eol_q;
   assign bus.m_full  = m_full_q;
endmodule

// File: tb/tb_line_window_buffer.sv
// Bench for line_window_buffer: replicate and zero-fill instances driven in lockstep,
// checked by a per-column history model plus directed vectors.
module tb_line_window_buffer;
   localparam int DW = 8;
   localparam int MW = 16;
   localparam int NR = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] cfg_width;
   logic       err_r, err_z;
   logic       s_valid, s_sof, s_eol, m_ready;
   logic [7:0] s_data;

   int n_chk  = 0;
   int n_fail = 0;

   line_window_buffer_if #(.DATA_WIDTH(DW), .NUM_ROWS(NR)) bus_r ();
   line_window_buffer_if #(.DATA_WIDTH(DW), .NUM_ROWS(NR)) bus_z ();

   assign bus_r.s_valid = s_valid;
   assign bus_r.s_data  = s_data;
   assign bus_r.s_sof   = s_sof;
   assign bus_r.s_eol   = s_eol;
   assign bus_r.m_ready = m_ready;
   assign bus_z.s_valid = s_valid;
   assign bus_z.s_data  = s_data;
   assign bus_z.s_sof   = s_sof;
   assign bus_z.s_eol   = s_eol;
   assign bus_z.m_ready = m_ready;

   line_window_buffer #(.DATA_WIDTH(DW), .MAX_WIDTH(MW), .NUM_ROWS(NR), .BORDER_MODE(0)) dut_r (
      .clk(clk), .rst(rst), .cfg_width(cfg_width), .bus(bus_r), .err_eol(err_r));
   line_window_buffer #(.DATA_WIDTH(DW), .MAX_WIDTH(MW), .NUM_ROWS(NR), .BORDER_MODE(1)) dut_z (
      .clk(clk), .rst(rst), .cfg_width(cfg_width), .bus(bus_z), .err_eol(err_z));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] r;
      logic [31:0] z;
      logic        sof;
      logic        eol;
      logic        full;
   } exp_t;

   exp_t       expq[$];
   logic [7:0] hist[MW][$];   // every pixel ever written to each column, oldest first
   int         mcol, mline, mw;
   bit         merr;
   logic [31:0] log_r[$], log_z[$];
   bit          log_full[$];

   function automatic int clampw(input int w);
      return (w == 0 || w > MW) ? MW : w;
   endfunction

   task automatic model_accept();
      int c, ln, w, fill, n;
      exp_t e;
      c    = s_sof ? 0 : mcol;
      ln   = s_sof ? 0 : mline;
      w    = s_sof ? clampw(int'(cfg_width)) : mw;
      fill = (ln > NR-1) ? NR-1 : ln;
      n    = hist[c].size();
      e.r = '0; e.z = '0;
      e.r[7:0] = s_data; e.z[7:0] = s_data;
      for (int k = 1; k < NR; k++) begin
         if (k <= fill) begin
            e.r[k*8 +: 8] = hist[c][n-k];
            e.z[k*8 +: 8] = hist[c][n-k];
         end else begin
            e.r[k*8 +: 8] = (fill == 0) ? s_data : hist[c][n-fill];
         end
      end
      e.sof = s_sof; e.eol = s_eol; e.full = (fill == NR-1);
      expq.push_back(e);
      hist[c].push_back(s_data);
      if (s_eol != (c == w-1)) merr = 1'b1;
      if (s_eol || c == w-1) begin mcol = 0; mline = ln + 1; end
      else begin mcol = c + 1; mline = ln; end
      mw = w;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         mcol = 0; mline = 0; merr = 1'b0; mw = clampw(int'(cfg_width));
         expq.delete();
      end else begin
         chk("err_eol_r", 32'(err_r), 32'(merr));
         chk("err_eol_z", 32'(err_z), 32'(merr));
         chk("m_valid_pair", 32'(bus_z.m_valid), 32'(bus_r.m_valid));
         if (bus_r.m_valid && m_ready) begin
            if (expq.size() == 0) begin
               chk("unexpected_beat", 32'(expq.size()), 32'd1);
            end else begin
               exp_t e;
               e = expq.pop_front();
               chk("rows_replicate", bus_r.m_rows, e.r);
               chk("rows_zero", bus_z.m_rows, e.z);
               chk("flags_r", {29'd0, bus_r.m_sof, bus_r.m_eol, bus_r.m_full}, {29'd0, e.sof, e.eol, e.full});
               chk("flags_z", {29'd0, bus_z.m_sof, bus_z.m_eol, bus_z.m_full}, {29'd0, e.sof, e.eol, e.full});
            end
            log_r.push_back(bus_r.m_rows);
            log_z.push_back(bus_z.m_rows);
            log_full.push_back(bus_r.m_full);
         end
         if (s_valid && bus_r.s_ready) model_accept();
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [7:0] d, input logic sof, input logic eol);
      int cyc = 0;
      bit acc = 0;
      s_valid = 1'b1; s_data = d; s_sof = sof; s_eol = eol;
      while (!acc && cyc < 200) begin
         @(negedge clk); acc = bus_r.s_ready;
         @(posedge clk); #1;
         cyc++;
      end
      if (!acc) chk("send_timeout", 32'(cyc), 32'd0);
      s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
   endtask

   task automatic idle(input int n);
      s_valid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic stream_frame(input int lines, input int w);
      for (int r = 0; r < lines; r++)
         for (int c = 0; c < w; c++)
            send(8'((r+1)*16 + c), (r == 0 && c == 0), (c == w-1));
   endtask

   task automatic do_reset();
      s_valid = 1'b0; rst = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b0;
   endtask

   typedef struct {
      int          idx;
      logic [31:0] r;
      logic [31:0] z;
      logic        full;
   } vec_t;

   vec_t tbl[5];
   bit   rdone;

   initial begin
      int base, c, w;
      logic [31:0] snap;
      logic sof, eol;

      tbl[0] = '{0,  32'h10101010, 32'h00000010, 1'b0};
      tbl[1] = '{4,  32'h10101020, 32'h00001020, 1'b0};
      tbl[2] = '{9,  32'h11112131, 32'h00112131, 1'b0};
      tbl[3] = '{14, 32'h12223242, 32'h12223242, 1'b1};
      tbl[4] = '{15, 32'h13233343, 32'h13233343, 1'b1};

      s_valid = 0; s_data = 0; s_sof = 0; s_eol = 0; m_ready = 1; cfg_width = 5'd4;
      do_reset();

      @(negedge clk);
      chk("reset_m_valid", 32'(bus_r.m_valid), 32'd0);
      chk("reset_m_rows", bus_r.m_rows, 32'd0);
      chk("reset_flags", {29'd0, bus_r.m_sof, bus_r.m_eol, bus_r.m_full}, 32'd0);
      chk("reset_s_ready", 32'(bus_r.s_ready), 32'd1);
      @(posedge clk); #1;

      // full window and border masking
      base = log_r.size();
      stream_frame(4, 4);
      idle(3);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("tbl%0d_rows_r", i), log_r[base + tbl[i].idx], tbl[i].r);
         chk($sformatf("tbl%0d_rows_z", i), log_z[base + tbl[i].idx], tbl[i].z);
         chk($sformatf("tbl%0d_full", i), 32'(log_full[base + tbl[i].idx]), 32'(tbl[i].full));
      end

      // backpressure mid-line
      base = log_r.size();
      fork
         stream_frame(4, 4);
         begin
            repeat (6) @(posedge clk);
            #1 m_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               if (i == 0) snap = bus_r.m_rows;
               chk("stall_rows_stable", bus_r.m_rows, snap);
               chk("stall_s_ready", 32'(bus_r.s_ready), 32'd0);
               chk("stall_m_valid", 32'(bus_r.m_valid), 32'd1);
               @(posedge clk);
            end
            #1 m_ready = 1'b1;
         end
      join
      idle(3);
      chk("bp_beat_count", 32'(log_r.size() - base), 32'd16);

      // early eol at col 1
      send(8'h10, 1, 0);
      send(8'h11, 0, 1);
      send(8'h20, 0, 0);
      idle(2);
      chk("early_eol_err", 32'(err_r), 32'd1);
      chk("early_eol_wrap", log_r[log_r.size()-1], 32'h10101020);
      send(8'h21, 0, 0); send(8'h22, 0, 0); send(8'h23, 0, 1);
      idle(2);
      chk("err_sticky", 32'(err_r), 32'd1);

      // mid-frame sof, then reset inside the second frame
      stream_frame(1, 4);
      send(8'h70, 0, 0); send(8'h71, 0, 0);
      send(8'h55, 1, 0);
      idle(2);
      chk("midsof_rows_r", log_r[log_r.size()-1], 32'h55555555);
      chk("midsof_rows_z", log_z[log_z.size()-1], 32'h00000055);
      chk("midsof_full", 32'(log_full[log_full.size()-1]), 32'd0);
      send(8'h56, 0, 0); send(8'h57, 0, 0);
      do_reset();
      @(negedge clk);
      chk("rst_m_valid", 32'(bus_r.m_valid), 32'd0);
      chk("rst_err_eol", 32'(err_r), 32'd0);
      @(posedge clk); #1;

      // width-1 frame: every pixel is both column 0 and a line end
      cfg_width = 5'd1;
      send(8'hA0, 1, 1); send(8'hA1, 0, 1); send(8'hA2, 0, 1); send(8'hA3, 0, 1);
      idle(2);
      chk("w1_rows", log_r[log_r.size()-1], 32'hA0A1A2A3);
      chk("w1_full", 32'(log_full[log_full.size()-1]), 32'd1);
      chk("w1_err", 32'(err_r), 32'd0);

      // prime every column at full width, then random traffic
      cfg_width = 5'd16;
      stream_frame(4, 16);
      rdone = 1'b0;
      fork
         begin
            for (int i = 0; i < 400; i++) begin
               if ($urandom % 5 == 0) idle(1);
               sof = ($urandom % 60 == 0);
               if (sof) cfg_width = 5'($urandom_range(0, 20));
               c = sof ? 0 : mcol;
               w = sof ? clampw(int'(cfg_width)) : mw;
               eol = (c == w-1) ? ($urandom % 16 != 0) : ($urandom % 32 == 0);
               send(8'($urandom), sof, eol);
            end
            rdone = 1'b1;
         end
         begin
            while (!rdone) begin
               @(posedge clk); #1;
               m_ready = ($urandom % 4) != 0;
            end
            m_ready = 1'b1;
         end
      join
      idle(4);
      chk("queue_drained", 32'(expq.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/line_window_buffer.md
# line_window_buffer

Streaming multi-row line buffer for the upscaler's vertical-window stage. It accepts one pixel per cycle over a valid/ready handshake and presents a vertical column of `NUM_ROWS` pixels for the same image column. It generalises the fixed 4-row delay line with a parametrised row count, a runtime image width up to `MAX_WIDTH`, and frame/line markers. Top-of-frame border handling is selectable, and output is registered with backpressure. It sits between the pixel source and the interpolation kernel.

## Interface
- `DATA_WIDTH`, 8: bits per pixel (24 for packed RGB).
- `MAX_WIDTH`, 1024: maximum pixels per line; sets RAM depth.
- `NUM_ROWS`, 4: rows in the output window, ≥2.
- `BORDER_MODE`, 0: 0 = replicate oldest valid row, 1 = zero-fill.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cfg_width` in `$clog2(MAX_WIDTH+1)`: active line width.
  - Sampled at reset release and on each accepted `s_sof`.
  - 0 or >`MAX_WIDTH` is treated as `MAX_WIDTH`.
- `s_valid` in 1, `s_ready` out 1, `s_data` in `DATA_WIDTH`: input pixel handshake.
- `s_sof` in 1: first pixel of frame. `s_eol` in 1: last pixel of line.
- `m_valid` out 1, `m_ready` in 1: output handshake.
- `m_rows` out `NUM_ROWS*DATA_WIDTH`: slice k holds the pixel k lines above the current one. Slice 0 is the current pixel.
- `m_sof`, `m_eol` out 1: markers aligned with `m_rows`.
- `m_full` out 1: all `NUM_ROWS` taps hold real image data.
- `err_eol` out 1: sticky; set when a line's length is inconsistent with the latched width.

## Operation
- Accept occurs when `s_valid && s_ready`. `s_ready = !m_valid || m_ready`.
- Column pointer `col` runs 0..W-1, where W is the latched width.
  - Wraps to 0 after the pixel at W-1, or after any accepted `s_eol`.
  - Each line end increments `row_fill`, which saturates at `NUM_ROWS-1`.
- An accepted `s_sof` forces that pixel to `col`=0 with `row_fill`=0, then latches `cfg_width`.
- Storage is one RAM of depth `MAX_WIDTH` and word width `(NUM_ROWS-1)*DATA_WIDTH`. Word slice j holds tap j+1.
- On accept, the RAM is read and written at `col` in the same cycle, read-first.
  - New word = {old taps 1..NUM_ROWS-2, `s_data`}, i.e. shifted by one row.
- Tap k (k≥1) is valid iff k ≤ `row_fill`. An invalid tap outputs:
  - `BORDER_MODE`=0: tap `row_fill`'s value. When `row_fill`=0, this is `s_data` itself.
  - `BORDER_MODE`=1: zero.
- `m_full` = (`row_fill` == `NUM_ROWS-1`) at the moment of accept.
- `err_eol` sets in either case:
  - `s_eol` is accepted with `col` ≠ W-1.
  - `col` wraps at W-1 without `s_eol`.
  - Only `rst` clears it. The stream continues regardless.
- `s_sof` and `s_eol` on the same pixel (width-1 frame) are legal. The pixel is col 0 and the line ends.
- Stale RAM contents are never visible, because masking depends only on `row_fill`.

## Timing
- Latency: exactly 1 cycle from accept to `m_valid` high with that pixel's window.
- Throughput: 1 pixel/cycle while `m_ready` is high.
- While `m_valid && !m_ready`, all `m_*` outputs hold stable and `s_ready` is 0.
- Reset values: `m_valid`=0, `m_rows`=0, `m_sof`=0, `m_eol`=0, `m_full`=0, `err_eol`=0, `col`=0, `row_fill`=0. `s_ready`=1 in the first cycle after reset.
  - Reset mid-frame discards the output register and the counters. RAM is not cleared.
- Output register load and consume in the same cycle is legal and loses no data.

## Structure
- `line_buf_pkg`: `BORDER_REPLICATE`=0 and `BORDER_ZERO`=1 constants, plus a width-clamp function.
- Sub-module `line_ram`: single-port, read-first, synchronous-write RAM, behavioural.
- The top level holds the counters, tap masking and output register.

## Test plan
Config for all scenarios: `DATA_WIDTH`=8, `MAX_WIDTH`=16, `NUM_ROWS`=4, `cfg_width`=4. Pixel value = (row+1)*16+col.
- Reset: assert `rst` 2 cycles → all outputs 0 and `s_ready`=1 the next cycle.
- Full window: stream 4 lines; at row 3 col 2 → `m_rows` slices 0..3 = 0x42, 0x32, 0x22, 0x12, with `m_full`=1.
- Border handling: at row 1 col 0 →
  - replicate mode: 0x20, 0x10, 0x10, 0x10, with `m_full`=0.
  - zero mode: 0x20, 0x10, 0x00, 0x00.
- Backpressure: hold `m_ready` low 3 cycles mid-line → `m_rows` stable and `s_ready`=0; all 16 pixels emerge in order with none lost or duplicated.
- Early `s_eol` at col 1 → `err_eol`=1 (sticky); next pixel is at col 0 and `row_fill` has incremented.
- Mid-frame `s_sof`, then `rst` during the second frame → `row_fill` restarts (replicate taps = current pixel); after `rst`, `m_valid`=0 and `err_eol`=0.
